// File: rtl/hdmi_axis_video_out.sv
// AXI4-Stream to raster video front end for the HDMI output path.
// Pixels are buffered in a small first-word-fall-through FIFO, stream frames are
// locked to the free-running raster via tuser/tlast, and the registered
// hsync/vsync/de/pixel outputs feed the TMDS encoders.
module hdmi_axis_video_out #(
    parameter int                DATA_W     = 24,
    parameter int                FIFO_DEPTH = 16,
    parameter int                H_ACTIVE   = 1280,
    parameter int                H_FP       = 110,
    parameter int                H_SYNC     = 40,
    parameter int                H_BP       = 220,
    parameter int                V_ACTIVE   = 720,
    parameter int                V_FP       = 5,
    parameter int                V_SYNC     = 5,
    parameter int                V_BP       = 20,
    parameter bit                HS_POL     = 1'b1,
    parameter bit                VS_POL     = 1'b1,
    parameter logic [DATA_W-1:0] IDLE_COLOR = '0
) (
    input  logic              clk_pix,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_axis_video_data,
    input  logic              s_axis_video_valid,
    output logic              s_axis_video_ready,
    input  logic              s_axis_video_last,
    input  logic              s_axis_video_user,
    input  logic              status_clr,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [DATA_W-1:0] vid_data,
    output logic              frame_locked,
    output logic              underflow,
    output logic              sof_err,
    output logic              eol_err
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int BW      = DATA_W + 2;

    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST_COL = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_MAX      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_MAX      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t state;

    logic [HW-1:0] sx;
    logic [VW-1:0] sy;

    logic [BW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;

    logic              empty;
    logic              full;
    logic [BW-1:0]     head;
    logic              head_user;
    logic              head_last;
    logic [DATA_W-1:0] head_data;
    logic              active;
    logic              at_origin;
    logic              frame_end;
    logic              run_slot;
    logic              misplaced_sof;
    logic              flush;
    logic              pop;
    logic              push;
    logic              sof_set;
    logic              eol_set;

    assign empty     = (level == '0);
    assign full      = (level == LEVEL_FULL);
    assign head      = mem[rd_ptr];
    assign head_user = head[BW-1];
    assign head_last = head[BW-2];
    assign head_data = head[DATA_W-1:0];

    assign active    = (sx < H_ACT) && (sy < V_ACT);
    assign at_origin = (sx == '0) && (sy == '0);
    assign frame_end = (sx == H_MAX) && (sy == V_MAX);

    // A pixel slot that must be served from the FIFO while locked.
    assign run_slot      = (state == RUN) && active;
    // A start-of-frame beat at the head anywhere but the origin means the
    // stream and raster disagree; the beat is held for the next frame.
    assign misplaced_sof = head_user && !at_origin;
    assign flush         = run_slot && empty;
    assign pop           = run_slot && !empty && !misplaced_sof;
    assign sof_set       = run_slot && !empty && misplaced_sof;
    assign eol_set       = pop && (head_last != (sx == H_LAST_COL));

    // While seeking everything is accepted so stale beats drain; otherwise
    // backpressure purely on FIFO occupancy, ignoring a same-cycle pop.
    assign s_axis_video_ready = (state == SEEK) || !full;
    assign push = s_axis_video_valid && s_axis_video_ready && !flush
                  && ((state != SEEK) || s_axis_video_user);

    // Free-running raster position counters.
    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) begin
            sx <= '0;
            sy <= '0;
        end else if (sx == H_MAX) begin
            sx <= '0;
            sy <= (sy == V_MAX) ? '0 : sy + VW'(1);
        end else begin
            sx <= sx + HW'(1);
        end
    end

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge clk_pix) begin
        if (push) begin
            mem[wr_ptr] <= {s_axis_video_user, s_axis_video_last, s_axis_video_data};
        end
    end

    // FIFO pointers and occupancy, with a single-cycle flush on underflow.
    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Lock state machine together with the registered video outputs.
    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) begin
            state        <= SEEK;
            frame_locked <= 1'b0;
            hsync        <= ~HS_POL;
            vsync        <= ~VS_POL;
            de           <= 1'b0;
            vid_data     <= '0;
        end else begin
            hsync <= ((sx >= HS_START) && (sx <= HS_END)) ? HS_POL : ~HS_POL;
            vsync <= ((sy >= VS_START) && (sy <= VS_END)) ? VS_POL : ~VS_POL;
            de    <= active;
            if (!active) begin
                vid_data <= '0;
            end else if (pop) begin
                vid_data <= head_data;
            end else begin
                vid_data <= IDLE_COLOR;
            end

            case (state)
                SEEK: begin
                    if (push) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (frame_end && !empty) begin
                        state        <= RUN;
                        frame_locked <= 1'b1;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state        <= SEEK;
                        frame_locked <= 1'b0;
                    end else if (sof_set) begin
                        state        <= ARMED;
                        frame_locked <= 1'b0;
                    end
                end
                default: begin
                    state        <= SEEK;
                    frame_locked <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) begin
            underflow <= 1'b0;
            sof_err   <= 1'b0;
            eol_err   <= 1'b0;
        end else begin
            underflow <= flush   ? 1'b1 : (status_clr ? 1'b0 : underflow);
            sof_err   <= sof_set ? 1'b1 : (status_clr ? 1'b0 : sof_err);
            eol_err   <= eol_set ? 1'b1 : (status_clr ? 1'b0 : eol_err);
        end
    end

endmodule
